// File: rtl/uart_periph_if.sv
// uart_periph_if: peripheral bus request/response signals between a bus master and the UART
interface uart_periph_if;
  logic        req;
  logic        gnt;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;
  modport master(output req, wen, strb, addr, wdata, input gnt, rdata, error);
  modport slave(input req, wen, strb, addr, wdata, output gnt, rdata, error);
endinterface

// File: rtl/uart_periph.sv
// uart_periph: memory-mapped UART with TX/RX FIFOs and sticky errors; IER/irq built only with UART_PERIPH_IRQ_EN
module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       g_clk,
  input  logic       g_resetn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign dout = mem[rp[AW-1:0]];
  // read/write pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge g_clk)
    if (!g_resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  // byte storage
  always_ff @(posedge g_clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

module uart_periph #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEF_BIT_RATE = 256_000,
  parameter int DIV_W        = 16,
  parameter int TX_DEPTH     = 8,
  parameter int RX_DEPTH     = 8
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  output logic         g_clk_req,
  input  logic         uart_rx,
  output logic         uart_tx,
  output logic         irq,
  uart_periph_if.slave memif
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT} st_t;
  st_t tx_st, tx_nx, rx_st, rx_nx;
  logic [4:0] ctrl, a;
  logic [DIV_W-1:0] div, per, tx_cnt, tx_per, rx_cnt, rx_per, rx_tgt;
  logic [2:0] flags, set, w1c, tx_bit, rx_bit;
  logic [7:0] tx_sh, rx_sh, tx_dout, rx_dout;
  logic tx_par, tx_pen, tx_stop2, rx_pen, rx_podd, rx_perr;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_push, rx_push, rx_pop;
  logic tx_end, tx_last, tx_go, tx_idle, rx_end, rx_fall, rx_done;
  logic [1:0] rx_s;
  logic rxd, rxd_q, rd, wr, bad, unused;
  logic [31:0] rd_v;
`ifdef UART_PERIPH_IRQ_EN
  logic [2:0] ier;
`endif
  assign a = memif.addr[4:0];
  assign rd = memif.req && !memif.wen;
  assign wr = memif.req && memif.wen && memif.strb[0];
  assign memif.gnt = 1'b1;
  assign unused = ^{memif.addr[31:5], memif.wdata[31:DIV_W], memif.strb[3:1]};
  assign per = div < DIV_W'(4) ? DIV_W'(4) : div;
  assign rxd = rx_s[1];
  assign tx_push = wr && a == 5'h04 && !tx_full;
  assign rx_pop = rd && a == 5'h00 && !rx_empty;
  assign w1c = wr && a == 5'h08 ? memif.wdata[6:4] : 3'd0;
  assign tx_idle = tx_empty && tx_st == IDLE;
  assign g_clk_req = memif.req || tx_st != IDLE || rx_st != IDLE || !tx_empty || !rxd;

  uart_fifo #(.DEPTH(TX_DEPTH)) u_txf (.g_clk(g_clk), .g_resetn(g_resetn), .push(tx_push), .pop(tx_go),
    .din(memif.wdata[7:0]), .dout(tx_dout), .empty(tx_empty), .full(tx_full));
  uart_fifo #(.DEPTH(RX_DEPTH)) u_rxf (.g_clk(g_clk), .g_resetn(g_resetn), .push(rx_push), .pop(rx_pop),
    .din(rx_sh), .dout(rx_dout), .empty(rx_empty), .full(rx_full));

  assign tx_end = tx_cnt == tx_per - 1'b1;
  assign tx_last = tx_st == STOP && tx_end && (tx_bit[0] || !tx_stop2);
  assign tx_go = (tx_st == IDLE || tx_last) && ctrl[1] && !tx_empty;
  // TX next state and serial line level
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      IDLE:    tx_nx = tx_go ? START : IDLE;
      START:   tx_nx = tx_end ? DATA : START;
      DATA:    tx_nx = tx_end && tx_bit == 3'd7 ? (tx_pen ? PARITY : STOP) : DATA;
      PARITY:  tx_nx = tx_end ? STOP : PARITY;
      STOP:    tx_nx = tx_go ? START : tx_last ? IDLE : STOP;
      default: tx_nx = IDLE;
    endcase
    uart_tx = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PARITY ? tx_par : 1'b1;
  end
  // TX state, bit timer and frame settings latched at frame start
  always_ff @(posedge g_clk)
    if (!g_resetn) begin
      tx_st <= IDLE;
      tx_cnt <= '0;
      tx_per <= DIV_W'(4);
      tx_bit <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      tx_pen <= 1'b0;
      tx_stop2 <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      tx_cnt <= tx_go || tx_end ? '0 : tx_cnt + 1'b1;
      if (tx_go) begin
        tx_per <= per;
        tx_pen <= ctrl[2];
        tx_stop2 <= ctrl[4];
        tx_par <= ^tx_dout ^ ctrl[3];
        tx_sh <= tx_dout;
        tx_bit <= '0;
      end else if (tx_end && (tx_st == DATA || tx_st == STOP)) begin
        tx_bit <= tx_bit + 1'b1;
        if (tx_st == DATA) tx_sh <= tx_sh >> 1;
      end
    end

  assign rx_fall = rx_st == IDLE && rxd_q && !rxd && ctrl[0];
  assign rx_tgt = rx_st == START ? (rx_per >> 1) - 1'b1 : rx_per - 1'b1;
  assign rx_end = rx_cnt == rx_tgt;
  assign rx_done = rx_st == STOP && rx_end;
  assign set = {rx_done && !rxd && rx_sh == 8'd0,
                rx_done && (!rxd && rx_sh != 8'd0 || rxd && rx_perr),
                rx_done && rxd && !rx_perr && rx_full && !rx_pop};
  assign rx_push = rx_done && rxd && !rx_perr && (!rx_full || rx_pop);
  // RX next state
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      IDLE:    rx_nx = rx_fall ? START : IDLE;
      START:   rx_nx = rx_end ? (rxd ? IDLE : DATA) : START;
      DATA:    rx_nx = rx_end && rx_bit == 3'd7 ? (rx_pen ? PARITY : STOP) : DATA;
      PARITY:  rx_nx = rx_end ? STOP : PARITY;
      STOP:    rx_nx = rx_end ? (rxd ? IDLE : WAIT) : STOP;
      default: rx_nx = rxd ? IDLE : WAIT;
    endcase
  end
  // RX synchroniser, mid-bit sampling and parity check
  always_ff @(posedge g_clk)
    if (!g_resetn) begin
      rx_st <= IDLE;
      rx_s <= 2'b11;
      rxd_q <= 1'b1;
      rx_cnt <= '0;
      rx_per <= DIV_W'(4);
      rx_bit <= '0;
      rx_sh <= '0;
      rx_pen <= 1'b0;
      rx_podd <= 1'b0;
      rx_perr <= 1'b0;
    end else begin
      rx_st <= rx_nx;
      rx_s <= {rx_s[0], uart_rx};
      rxd_q <= rxd;
      rx_cnt <= rx_fall || rx_end ? '0 : rx_cnt + 1'b1;
      if (rx_fall) begin
        rx_per <= per;
        rx_pen <= ctrl[2];
        rx_podd <= ctrl[3];
        rx_perr <= 1'b0;
        rx_bit <= '0;
      end else if (rx_end && rx_st == DATA) begin
        rx_sh <= {rxd, rx_sh[7:1]};
        rx_bit <= rx_bit + 1'b1;
      end else if (rx_end && rx_st == PARITY) rx_perr <= rxd != (^rx_sh ^ rx_podd);
    end

  // register read mux and address decode
  always_comb begin
    rd_v = '0;
    bad = 1'b0;
    case (a)
      5'h00:   rd_v = rx_empty ? 32'd0 : {24'd0, rx_dout};
      5'h04:   rd_v = '0;
      5'h08:   rd_v = {25'd0, flags, tx_full, tx_idle, rx_full, !rx_empty};
      5'h0C:   rd_v = {27'd0, ctrl};
      5'h10:   rd_v = 32'(div);
`ifdef UART_PERIPH_IRQ_EN
      5'h14:   rd_v = {29'd0, ier};
`endif
      default: bad = 1'b1;
    endcase
  end
  // registered bus response, control registers and sticky flags (set beats clear)
  always_ff @(posedge g_clk)
    if (!g_resetn) begin
      memif.rdata <= '0;
      memif.error <= 1'b0;
      ctrl <= 5'h03;
      div <= DIV_W'(CLK_HZ / DEF_BIT_RATE);
      flags <= '0;
    end else begin
      memif.rdata <= rd ? rd_v : '0;
      memif.error <= memif.req && (bad || wr && a == 5'h04 && tx_full);
      if (wr && a == 5'h0C) ctrl <= memif.wdata[4:0];
      if (wr && a == 5'h10) div <= memif.wdata[DIV_W-1:0];
      flags <= flags & ~w1c | set;
    end
`ifdef UART_PERIPH_IRQ_EN
  // interrupt enables and registered interrupt
  always_ff @(posedge g_clk)
    if (!g_resetn) begin
      ier <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && a == 5'h14) ier <= memif.wdata[2:0];
      irq <= |(ier & {|flags, tx_idle, !rx_empty});
    end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: table-driven register checks plus serial sequences, bus responses via a scoreboard
module tb_uart_periph;
  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [31:0] mk;
    string       nm;
  } exp_t;
  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        err;
    string       nm;
  } vec_t;
`ifdef UART_PERIPH_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  logic g_clk = 1'b0, g_resetn = 1'b0, loop = 1'b0, rx_drv = 1'b1, req_d = 1'b0;
  logic g_clk_req, uart_rx, uart_tx, irq;
  int total = 0, bad = 0;
  exp_t sb[$];
  vec_t tbl[13];
  uart_periph_if memif();
  assign uart_rx = loop ? uart_tx : rx_drv;
  uart_periph dut (.g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .irq(irq), .memif(memif));
  always #5 g_clk = ~g_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(posedge g_clk) req_d <= memif.req;
  always @(negedge g_clk)
    if (req_d) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: response with no expectation");
      end else begin
        e = sb.pop_front();
        if (e.mk != 0) chk({e.nm, "_rdata"}, memif.rdata & e.mk, e.rd);
        chk({e.nm, "_err"}, {31'd0, memif.error}, {31'd0, e.err});
      end
    end

  task automatic op(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [31:0] rd,
                    input logic err, input string nm);
    @(negedge g_clk);
    memif.req = 1'b1;
    memif.wen = w;
    memif.addr = {27'd0, a};
    memif.wdata = d;
    memif.strb = 4'hF;
    sb.push_back('{rd, err, w ? 32'd0 : 32'hFFFF_FFFF, nm});
    @(negedge g_clk);
    memif.req = 1'b0;
    memif.wen = 1'b0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic err, input string nm);
    op(1'b1, a, d, 32'd0, err, nm);
  endtask
  task automatic rdc(input logic [4:0] a, input logic [31:0] rd, input string nm);
    op(1'b0, a, 32'd0, rd, 1'b0, nm);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge g_clk);
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stp);
    rx_drv = 1'b0;
    cyc(8);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      cyc(8);
    end
    rx_drv = stp;
    cyc(8);
    rx_drv = 1'b1;
    cyc(8);
  endtask
  task automatic tx_frame(input logic [7:0] b, input string nm);
    int n = 0;
    while (uart_tx !== 1'b0 && n < 100) begin
      @(posedge g_clk);
      #1 n++;
    end
    chk({nm, "_start_seen"}, {31'd0, n < 100}, 32'd1);
    repeat (4) @(posedge g_clk);
    #1 chk({nm, "_start"}, {31'd0, uart_tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(posedge g_clk);
      #1 chk($sformatf("%s_bit%0d", nm, i), {31'd0, uart_tx}, {31'd0, b[i]});
    end
    repeat (8) @(posedge g_clk);
    #1 chk({nm, "_stop"}, {31'd0, uart_tx}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    memif.req = 1'b0;
    memif.wen = 1'b0;
    memif.strb = 4'h0;
    memif.addr = '0;
    memif.wdata = '0;
    tbl[0]  = '{1'b0, 5'h0C, 32'h0, 32'h03, 1'b0, "ctrl_rst"};
    tbl[1]  = '{1'b0, 5'h10, 32'h0, 32'd195, 1'b0, "div_rst"};
    tbl[2]  = '{1'b0, 5'h08, 32'h0, 32'h04, 1'b0, "stat_rst"};
    tbl[3]  = '{1'b0, 5'h00, 32'h0, 32'h00, 1'b0, "rx_empty"};
    tbl[4]  = '{1'b0, 5'h18, 32'h0, 32'h00, 1'b1, "rd_unused18"};
    tbl[5]  = '{1'b0, 5'h14, 32'h0, 32'h00, !IRQ_ON, "rd_ier"};
    tbl[6]  = '{1'b1, 5'h10, 32'h8, 32'h00, 1'b0, "wr_div"};
    tbl[7]  = '{1'b0, 5'h10, 32'h0, 32'h08, 1'b0, "rd_div"};
    tbl[8]  = '{1'b1, 5'h0C, 32'h15, 32'h00, 1'b0, "wr_ctrl"};
    tbl[9]  = '{1'b0, 5'h0C, 32'h0, 32'h15, 1'b0, "rd_ctrl"};
    tbl[10] = '{1'b1, 5'h0C, 32'h3, 32'h00, 1'b0, "wr_ctrl3"};
    tbl[11] = '{1'b1, 5'h1C, 32'h0, 32'h00, 1'b1, "wr_unused1c"};
    tbl[12] = '{1'b0, 5'h0C, 32'h0, 32'h03, 1'b0, "rd_ctrl3"};
    cyc(3);
    g_resetn = 1'b1;
    cyc(1);
    chk("tx_rst", {31'd0, uart_tx}, 32'd1);
    chk("irq_rst", {31'd0, irq}, 32'd0);
    chk("clkreq_rst", {31'd0, g_clk_req}, 32'd0);
    for (int i = 0; i < 13; i++) op(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].err, tbl[i].nm);
    // single frame on the line
    wr(5'h04, 32'hA5, 1'b0, "tx_a5");
    tx_frame(8'hA5, "a5");
    cyc(8);
    rdc(5'h08, 32'h04, "stat_tx_idle");
    // loopback with odd parity and two stop bits
    wr(5'h0C, 32'h1F, 1'b0, "ctrl_loop");
    loop = 1'b1;
    wr(5'h04, 32'h00, 1'b0, "tx_00");
    wr(5'h04, 32'hFF, 1'b0, "tx_ff");
    wr(5'h04, 32'h3C, 1'b0, "tx_3c");
    cyc(400);
    rdc(5'h00, 32'h00, "lb_00");
    rdc(5'h00, 32'hFF, "lb_ff");
    rdc(5'h00, 32'h3C, "lb_3c");
    rdc(5'h08, 32'h04, "lb_stat");
    // TX FIFO overflow with TX disabled, then drain
    wr(5'h0C, 32'h01, 1'b0, "ctrl_txoff");
    for (int i = 0; i < 8; i++) wr(5'h04, 32'h10 + i, 1'b0, $sformatf("fill%0d", i));
    wr(5'h04, 32'hEE, 1'b1, "fill_ovf");
    rdc(5'h08, 32'h08, "stat_txfull");
    wr(5'h0C, 32'h03, 1'b0, "ctrl_txon");
    cyc(800);
    rdc(5'h08, 32'h07, "stat_drained");
    for (int i = 0; i < 8; i++) rdc(5'h00, 32'h10 + i, $sformatf("drain%0d", i));
    rdc(5'h00, 32'h00, "drain_extra");
    loop = 1'b0;
    // RX overrun
    for (int i = 0; i < 9; i++) send_rx(8'h40 + 8'(i), 1'b1);
    rdc(5'h08, 32'h17, "stat_ovr");
    for (int i = 0; i < 8; i++) rdc(5'h00, 32'h40 + i, $sformatf("ovr_rd%0d", i));
    wr(5'h08, 32'h10, 1'b0, "clr_ovr");
    rdc(5'h08, 32'h04, "stat_ovr_clr");
    // break, framing error, glitch
    rx_drv = 1'b0;
    cyc(96);
    rx_drv = 1'b1;
    cyc(10);
    rdc(5'h08, 32'h44, "stat_brk");
    rdc(5'h00, 32'h00, "brk_nopush");
    wr(5'h08, 32'h40, 1'b0, "clr_brk");
    send_rx(8'h55, 1'b0);
    rdc(5'h08, 32'h24, "stat_ferr");
    rdc(5'h00, 32'h00, "ferr_nopush");
    wr(5'h08, 32'h20, 1'b0, "clr_ferr");
    rx_drv = 1'b0;
    cyc(2);
    rx_drv = 1'b1;
    cyc(50);
    rdc(5'h08, 32'h04, "stat_glitch");
    // reset in the middle of a frame
    rx_drv = 1'b0;
    cyc(96);
    rx_drv = 1'b1;
    cyc(10);
    wr(5'h0C, 32'h1F, 1'b0, "ctrl_prerst");
    wr(5'h04, 32'h00, 1'b0, "tx_prerst");
    cyc(30);
    g_resetn = 1'b0;
    @(posedge g_clk);
    #1 chk("tx_midrst", {31'd0, uart_tx}, 32'd1);
    cyc(1);
    g_resetn = 1'b1;
    cyc(1);
    chk("clkreq_midrst", {31'd0, g_clk_req}, 32'd0);
    rdc(5'h0C, 32'h03, "ctrl_midrst");
    rdc(5'h10, 32'd195, "div_midrst");
    rdc(5'h08, 32'h04, "stat_midrst");
    rdc(5'h00, 32'h00, "rx_midrst");
    wr(5'h10, 32'h8, 1'b0, "div8_again");
    wr(5'h14, 32'h1, !IRQ_ON, "wr_ier");
    send_rx(8'h5A, 1'b1);
    chk("irq_rx", {31'd0, irq}, {31'd0, IRQ_ON});
    rdc(5'h00, 32'h5A, "rx_5a");
    cyc(2);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
